// File: rtl/corfifo_gray_ptr_sync.sv
// rtl/corfifo_gray_ptr_sync.sv - multi-channel Gray pointer synchroniser with hold, change strobe and optional step check
// Optional Gray step checking is enabled by defining COREFIFO_SYNC_GRAY_CHECK_EN.
module corfifo_gray_ptr_sync #(
    parameter int NUM_STAGES = 2,
    parameter int ADDRWIDTH  = 3,
    parameter int NUM_CH     = 1
) (
    input  logic                              clk,
    input  logic                              srst,
    input  logic [NUM_CH*(ADDRWIDTH+1)-1:0]   inp,
    input  logic                              freeze,
    input  logic [NUM_CH-1:0]                 err_clr,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]   sync_gray,
    output logic [NUM_CH*(ADDRWIDTH+1)-1:0]   sync_bin,
    output logic [NUM_CH-1:0]                 chg_pulse,
    output logic [NUM_CH-1:0]                 err_flag
);

    localparam int W  = ADDRWIDTH + 1;
    localparam int CW = NUM_CH * W;

    logic [CW-1:0] stage [NUM_STAGES];
    logic [CW-1:0] s_last;
    logic [CW-1:0] last_gray;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // The synchroniser chain keeps shifting during freeze so the newest
    // pointer is ready the moment the output stage is released.
    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= inp;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign s_last = stage[NUM_STAGES-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            last_gray <= '0;
            sync_bin  <= '0;
            chg_pulse <= '0;
        end else if (freeze) begin
            chg_pulse <= '0;
        end else begin
            last_gray <= s_last;
            for (int k = 0; k < NUM_CH; k++) begin
                sync_bin[k*W +: W] <= gray2bin(s_last[k*W +: W]);
                chg_pulse[k]       <= (s_last[k*W +: W] != last_gray[k*W +: W]);
            end
        end
    end

    assign sync_gray = last_gray;

`ifdef COREFIFO_SYNC_GRAY_CHECK_EN
    logic was_frozen;

    function automatic logic multi_bit(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a ^ b;
        return ((d & (d - 1'b1)) != '0);
    endfunction

    // The release cycle after a freeze carries an accumulated delta, so it is
    // exempt from the single-step check; a new error beats a clear.
    always_ff @(posedge clk) begin
        if (srst) begin
            was_frozen <= 1'b0;
            err_flag   <= '0;
        end else begin
            was_frozen <= freeze;
            if (!freeze) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!was_frozen && multi_bit(s_last[k*W +: W], last_gray[k*W +: W])) begin
                        err_flag[k] <= 1'b1;
                    end else if (err_clr[k]) begin
                        err_flag[k] <= 1'b0;
                    end
                end
            end
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = ^err_clr;
    assign err_flag       = '0;
`endif

endmodule

// File: doc/corfifo_gray_ptr_sync.md
CORFIFO_GRAY_PTR_SYNC -- requirements
Module: corfifo_gray_ptr_sync

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 2, meaning synchroniser flop stages per channel; legal values are 2 or more.
REQ-002 SHALL have parameter ADDRWIDTH, default 3, meaning pointer width is ADDRWIDTH+1 bits per channel.
REQ-003 SHALL have parameter NUM_CH, default 1, meaning the number of independent pointer channels.
REQ-004 SHALL have port clk, input, 1 bit: destination-domain clock; the block has one clock and all flops use its rising edge.
REQ-005 SHALL have port srst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port inp, input, NUM_CH*(ADDRWIDTH+1) bits: asynchronous Gray-coded pointers, channel k at bits [k*(ADDRWIDTH+1) +: ADDRWIDTH+1].
REQ-007 SHALL have port freeze, input, 1 bit: when high, hold the output registers.
REQ-008 SHALL have port err_clr, input, NUM_CH bits: per-channel clear for err_flag.
REQ-009 SHALL have port sync_gray, output, NUM_CH*(ADDRWIDTH+1) bits: synchronised Gray pointer, packed like inp.
REQ-010 SHALL have port sync_bin, output, NUM_CH*(ADDRWIDTH+1) bits: binary equivalent of sync_gray, packed like inp.
REQ-011 SHALL have port chg_pulse, output, NUM_CH bits: single-cycle strobe per channel when the synchronised value changes.
REQ-012 SHALL have port err_flag, output, NUM_CH bits: sticky per-channel flag for an illegal multi-bit Gray step.

Function
REQ-013 SHALL pass each channel through an NUM_STAGES-deep flop chain, s[0] through s[NUM_STAGES-1], which shifts every cycle regardless of freeze.
REQ-014 SHALL hold an output register stage per channel: last_gray, sync_bin, chg_pulse and err_flag.
REQ-015 SHALL, when freeze=0, update each cycle as follows: last_gray <= s_last; sync_bin <= gray2bin(s_last); chg_pulse <= (s_last != last_gray).
REQ-016 SHALL compute gray2bin as: bin[MSB] = g[MSB]; bin[i] = bin[i+1] XOR g[i].
REQ-017 SHALL drive sync_gray directly from last_gray.
REQ-018 SHALL give latency from inp sampled at an edge to sync_gray/sync_bin of exactly NUM_STAGES+1 clk edges, with chg_pulse asserted in the same cycle that sync_bin first shows the new value.
REQ-019 SHALL, when freeze=1, hold last_gray, sync_bin and err_flag, and force chg_pulse to 0.
REQ-020 SHALL, on the first unfrozen cycle after freeze, compare s_last against the held last_gray, so one chg_pulse covers all changes accumulated during freeze.
REQ-021 SHALL NOT flag an error for the accumulated freeze delta in REQ-020, because the error check is suppressed on that cycle.
REQ-022 SHALL treat pointer wrap-around as legal, e.g. Gray 1000 -> 0000 for ADDRWIDTH=3: one bit changes, chg_pulse=1, no error.
REQ-023 SHALL keep channels fully independent, with no cross-channel interaction.
REQ-024 SHALL, when err_clr[k]=1 and a new error on channel k occur in the same cycle, leave err_flag[k]=1 (set wins over clear).

Reset
REQ-025 SHALL, when srst=1 at a clk edge, clear all stage flops, last_gray, sync_bin, chg_pulse and err_flag to 0.
REQ-026 SHALL give srst priority over freeze and err_clr.
REQ-027 SHALL, after srst deasserts, produce no chg_pulse until s_last differs from 0.
REQ-028 SHALL, on reset mid-transfer, discard in-flight stage contents.

Configuration
REQ-029 SHALL, with macro COREFIFO_SYNC_GRAY_CHECK_EN defined, set err_flag[k] when freeze=0, the previous cycle was unfrozen, and popcount(s_last XOR last_gray) > 1; err_flag[k] stays set until err_clr[k] or srst.
REQ-030 SHALL, with COREFIFO_SYNC_GRAY_CHECK_EN undefined, tie err_flag to 0, ignore err_clr, and synthesise no compare logic.

Verification
REQ-031 SHALL cover: NUM_STAGES=2, ADDRWIDTH=3, inp 0000->0001 held -> sync_gray=0001, sync_bin=0001, chg_pulse=1 for exactly one cycle, 3 edges after capture.
REQ-032 SHALL cover: NUM_STAGES=4, inp steps 0011->0010 -> sync_bin goes 0010->0011 after 5 edges, and chg_pulse occurs once.
REQ-033 SHALL cover: with CHECK_EN defined, inp jumps 0000->0011 -> err_flag=1 and stays set; pulsing err_clr clears it; err_clr coincident with a new 0011->0000 jump -> err_flag stays 1.
REQ-034 SHALL cover: freeze=1 while inp walks 0000->0001->0011->0010, then freeze=0 -> one chg_pulse, sync_bin=0011, err_flag=0, and chg_pulse=0 throughout freeze.
REQ-035 SHALL cover: NUM_CH=2, channel 0 toggles 0000<->1000 (wrap) while channel 1 is held at 0110 -> channel 0 chg_pulse on every wrap with no error; channel 1 sync_bin=0100 with no pulses after the first.
REQ-036 SHALL cover: srst asserted mid-transfer with inp=0101 -> all outputs 0 on the next edge; after release, the first chg_pulse appears NUM_STAGES+1 edges later with sync_gray=0101.
